scan_chain_driver: RTL



---
 rtl/scan_pkg.sv | 24 ++
 rtl/scan_chain_driver_if.sv | 37 +++
 rtl/scan_clk_gen.sv | 49 ++++
 rtl/scan_chain_driver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan-chain initiator.
package scan_pkg;

  // Bits carried by every scan cell.
  localparam int unsigned NUM_IOS = 8;

  // Transaction sequencer states. The done cycle is produced on the edge that
  // returns to StIdle, so it has no state of its own.
  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StLatch,
    StSettle,
    StCapture,
    StShiftOut
  } scan_state_e;

  // Width of a counter that must hold num_designs * num_ios without wrapping.
  function automatic int unsigned bit_cnt_width(input int unsigned num_designs,
                                                input int unsigned num_ios);
    return $clog2(num_designs * num_ios + 1);
  endfunction

endpackage

// File: rtl/scan_chain_driver_if.sv
// Host-side request/response bundle of the scan-chain initiator.
interface scan_chain_driver_if #(
  parameter int unsigned SEL_W   = 9,
  parameter int unsigned NUM_IOS = 8
) ();

  logic               start;
  logic [SEL_W-1:0]   active_select;
  logic [NUM_IOS-1:0] inputs;
  logic               ready;
  logic               done;
  logic               err;
  logic [NUM_IOS-1:0] outputs;

  // Requester side: issues transactions and consumes the result.
  modport master (
    output start,
    output active_select,
    output inputs,
    input  ready,
    input  done,
    input  err,
    input  outputs
  );

  // Initiator side: accepts transactions and reports the result.
  modport slave (
    input  start,
    input  active_select,
    input  inputs,
    output ready,
    output done,
    output err,
    output outputs
  );

endinterface

// File: rtl/scan_clk_gen.sv
// Scan-clock phase generator: each bit is HALF_PERIOD low cycles followed by
// HALF_PERIOD high cycles while enabled; parked low with the phase cleared
// when disabled.
module scan_clk_gen #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic level,    // registered scan clock level
  output logic rise,     // first high cycle of the bit
  output logic fall,     // first low cycle of the bit
  output logic bit_end   // last high cycle of the bit
);

  localparam int unsigned PERIOD = 2 * HALF_PERIOD;
  localparam int unsigned CNT_W  = $clog2(PERIOD);

  localparam logic [CNT_W-1:0] LastPhase = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] HighPhase = CNT_W'(HALF_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q;

  // Next phase: advance while enabled, wrap at the end of a bit.
  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != LastPhase)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Level is derived from the next phase so it stays aligned with cnt_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= en && (cnt_d >= HighPhase);
    end
  end

  assign level   = level_q;
  assign rise    = en && (cnt_q == HighPhase);
  assign fall    = en && (cnt_q == '0);
  assign bit_end = en && (cnt_q == LastPhase);

endmodule

// File: rtl/scan_chain_driver.sv
// Initiator end of the scan chain: shifts a byte into one design, latches it,
// waits for it to settle, captures the design outputs and shifts them home.
module scan_chain_driver
  import scan_pkg::*;
#(
  parameter int unsigned NUM_DESIGNS   = 25,
  parameter int unsigned SEL_W         = 9,
  parameter int unsigned HALF_PERIOD   = 2,
  parameter int unsigned LATCH_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  scan_chain_driver_if.slave host,
  output logic               scan_clk_out,
  output logic               scan_data_out,
  output logic               scan_select,
  output logic               scan_latch_en,
  input  logic               scan_data_in
);

  localparam int unsigned BIT_W   = bit_cnt_width(NUM_DESIGNS, NUM_IOS);
  localparam int unsigned CYC_MAX = (LATCH_CYCLES > SETTLE_CYCLES) ? LATCH_CYCLES
                                                                   : SETTLE_CYCLES;
  localparam int unsigned CYC_W   = (CYC_MAX > 2) ? $clog2(CYC_MAX) : 1;

  scan_state_e        state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [BIT_W-1:0]   in_bits;
  logic [BIT_W-1:0]   out_bits;
  logic [CYC_W-1:0]   cyc_cnt_q;
  logic [NUM_IOS-1:0] in_sr_q;
  // Only the seven most recent returned bits are kept; the eighth is taken
  // straight from scan_data_in on the final shift.
  logic [NUM_IOS-2:0] out_hist_q;
  logic [NUM_IOS-1:0] outputs_q;
  logic               ready_q;
  logic               done_q;
  logic               err_q;
  logic               sdo_q;
  logic               ssel_q;
  logic               latch_q;

  logic               clk_en;
  logic               clk_level;
  logic               clk_rise;
  logic               clk_fall;
  logic               bit_end;
  logic               sel_bad;
  logic               last_bit;

  assign clk_en = state_q inside {StShiftIn, StCapture, StShiftOut};

  scan_clk_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (clk_en),
    .level   (clk_level),
    .rise    (clk_rise),
    .fall    (clk_fall),
    .bit_end (bit_end)
  );

  // Edge strobes are not needed: data moves on bit boundaries only.
  logic unused_strobes;
  assign unused_strobes = clk_rise ^ clk_fall;

  assign sel_bad  = 32'(host.active_select) >= NUM_DESIGNS;
  // Shift-in covers the target cell and every cell in front of it.
  assign in_bits  = BIT_W'((32'(host.active_select) + 32'd1) * NUM_IOS);
  // Shift-out drains the target cell and every cell behind it.
  assign out_bits = BIT_W'((NUM_DESIGNS - 32'(sel_q)) * NUM_IOS);
  assign last_bit = bit_cnt_q == BIT_W'(1);

  // Transaction sequencer with all scan and host outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      bit_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      in_sr_q    <= '0;
      out_hist_q <= '0;
      outputs_q  <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sdo_q      <= 1'b0;
      ssel_q     <= 1'b0;
      latch_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (host.start && ready_q) begin
            if (sel_bad) begin
              // Out-of-range target: finish at once, chain untouched.
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              sel_q     <= host.active_select;
              bit_cnt_q <= in_bits;
              sdo_q     <= host.inputs[NUM_IOS-1];
              in_sr_q   <= {host.inputs[NUM_IOS-2:0], 1'b0};
              ready_q   <= 1'b0;
              state_q   <= StShiftIn;
            end
          end
        end

        StShiftIn: begin
          if (bit_end) begin
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
            if (last_bit) begin
              sdo_q     <= 1'b0;
              latch_q   <= 1'b1;
              cyc_cnt_q <= CYC_W'(LATCH_CYCLES - 1);
              state_q   <= StLatch;
            end else begin
              // Zeros follow the payload byte to push it down the chain.
              sdo_q   <= in_sr_q[NUM_IOS-1];
              in_sr_q <= {in_sr_q[NUM_IOS-2:0], 1'b0};
            end
          end
        end

        StLatch: begin
          if (latch_q) begin
            if (cyc_cnt_q == '0) begin
              latch_q <= 1'b0;
            end else begin
              cyc_cnt_q <= cyc_cnt_q - CYC_W'(1);
            end
          end else if (SETTLE_CYCLES == 0) begin
            ssel_q  <= 1'b1;
            state_q <= StCapture;
          end else begin
            cyc_cnt_q <= CYC_W'(SETTLE_CYCLES - 1);
            state_q   <= StSettle;
          end
        end

        StSettle: begin
          if (cyc_cnt_q == '0) begin
            ssel_q  <= 1'b1;
            state_q <= StCapture;
          end else begin
            cyc_cnt_q <= cyc_cnt_q - CYC_W'(1);
          end
        end

        StCapture: begin
          if (bit_end) begin
            ssel_q    <= 1'b0;
            bit_cnt_q <= out_bits;
            state_q   <= StShiftOut;
          end
        end

        StShiftOut: begin
          if (bit_end) begin
            out_hist_q <= {out_hist_q[NUM_IOS-3:0], scan_data_in};
            bit_cnt_q  <= bit_cnt_q - BIT_W'(1);
            if (last_bit) begin
              outputs_q <= {out_hist_q, scan_data_in};
              done_q    <= 1'b1;
              ready_q   <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign host.ready    = ready_q;
  assign host.done     = done_q;
  assign host.err      = err_q;
  assign host.outputs  = outputs_q;

  assign scan_clk_out  = clk_level;
  assign scan_data_out = sdo_q;
  assign scan_select   = ssel_q;
  assign scan_latch_en = latch_q;

endmodule
